mem_stage: RTL and testbench

- Pipeline stage directly downstream of the ALU; consumes the ALU_MEM result (ALU data, store data, memory op, destination register).
- Performs data-memory loads/stores over a req/ack bus and registers the result for writeback.
- Non-memory ops pass through in one cycle.
- Raises `stall` to the upstream stages while a memory transaction is outstanding.

---
 rtl/mem_stage_if.sv | 49 ++++
 rtl/mem_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// ALU_MEM entry, data-memory req/ack bus and writeback port of mem_stage, grouped as one bundle.
// The misalign_trap signal exists only when MEM_MISALIGN_TRAP_EN is defined.
interface mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_store_data;
  logic [3:0]        in_mem_op;
  logic [REG_AW-1:0] in_rd;
  logic              in_reg_write;
  logic              stall;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [3:0]        dmem_wstrb;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_reg_write;
  logic              mem_err;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              misalign_trap;
`endif

  modport slave (
    input  in_valid, in_data, in_store_data, in_mem_op, in_rd, in_reg_write,
    input  dmem_rdata, dmem_ack,
    output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output wb_valid, wb_data, wb_rd, wb_reg_write, mem_err
`ifdef MEM_MISALIGN_TRAP_EN
    , output misalign_trap
`endif
  );

  modport master (
    output in_valid, in_data, in_store_data, in_mem_op, in_rd, in_reg_write,
    output dmem_rdata, dmem_ack,
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  wb_valid, wb_data, wb_rd, wb_reg_write, mem_err
`ifdef MEM_MISALIGN_TRAP_EN
    , input misalign_trap
`endif
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: ALU ops write back after 1 cycle, loads/stores after >=2 cycles over req/ack; stall held while BUSY.
// MEM_MISALIGN_TRAP_EN turns misaligned accesses into a 1-cycle trap instead of silently aligning them.
module mem_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_stage_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  logic [0:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        sz_q, sz_d;
  logic              uns_q, uns_d;
  logic              st_q, st_d;
  logic [1:0]        off_q, off_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              rw_q, rw_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              wbv_q, wbv_d;
  logic [DATA_W-1:0] wbd_q, wbd_d;
  logic [REG_AW-1:0] wbrd_q, wbrd_d;
  logic              wbrw_q, wbrw_d;
  logic              err_q, err_d;

  logic [1:0]        size;
  logic              mem_op;
  logic              take_mem;
  logic [1:0]        eff_off;
  logic [3:0]        st_wstrb;
  logic [DATA_W-1:0] st_wdata;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_val;

  assign size   = bus.in_mem_op[1:0];
  assign mem_op = (size != 2'b00);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misal;
  logic trap_q, trap_d;
  assign misal    = ((size == 2'b10) && bus.in_data[0]) ||
                    ((size == 2'b11) && (bus.in_data[1:0] != 2'b00));
  assign take_mem = bus.in_valid && mem_op && !misal;
  assign bus.misalign_trap = trap_q;
`else
  assign take_mem = bus.in_valid && mem_op;
`endif

  // Lane offset after forcing natural alignment; also the load-extraction offset.
  assign eff_off = (size == 2'b11) ? 2'b00 :
                   (size == 2'b10) ? {bus.in_data[1], 1'b0} : bus.in_data[1:0];

  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = bus.in_store_data;
    if (size == 2'b01) begin
      st_wstrb = 4'b0001 << eff_off;
      st_wdata = {4{bus.in_store_data[7:0]}};
    end else if (size == 2'b10) begin
      st_wstrb = eff_off[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{bus.in_store_data[15:0]}};
    end
  end

  assign byte_sel = bus.dmem_rdata[{off_q, 3'b000} +: 8];
  assign half_sel = off_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

  always_comb begin
    load_val = bus.dmem_rdata;
    if (sz_q == 2'b01)
      load_val = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    else if (sz_q == 2'b10)
      load_val = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sz_d    = sz_q;
    uns_d   = uns_q;
    st_d    = st_q;
    off_d   = off_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wbv_d   = 1'b0;
    wbd_d   = wbd_q;
    wbrd_d  = wbrd_q;
    wbrw_d  = wbrw_q;
    err_d   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap_d  = 1'b0;
`endif
    if (state_q == ST_IDLE) begin
      if (bus.in_valid) begin
        if (!mem_op) begin
          wbv_d  = 1'b1;
          wbd_d  = bus.in_data;
          wbrd_d = bus.in_rd;
          wbrw_d = bus.in_reg_write && (bus.in_rd != '0);
        end
`ifdef MEM_MISALIGN_TRAP_EN
        else if (misal) begin
          wbv_d  = 1'b1;
          wbd_d  = bus.in_data;
          wbrd_d = bus.in_rd;
          wbrw_d = 1'b0;
          trap_d = 1'b1;
        end
`endif
        else begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          sz_d    = size;
          uns_d   = bus.in_mem_op[3];
          st_d    = bus.in_mem_op[2];
          off_d   = eff_off;
          rd_d    = bus.in_rd;
          rw_d    = bus.in_reg_write && (bus.in_rd != '0) && !bus.in_mem_op[2];
          req_d   = 1'b1;
          we_d    = bus.in_mem_op[2];
          addr_d  = {bus.in_data[DATA_W-1:2], 2'b00};
          wdata_d = bus.in_mem_op[2] ? st_wdata : '0;
          wstrb_d = bus.in_mem_op[2] ? st_wstrb : 4'b0000;
        end
      end
    end else begin
      if (bus.dmem_ack) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        req_d   = 1'b0;
        wbv_d   = 1'b1;
        wbd_d   = st_q ? '0 : load_val;
        wbrd_d  = rd_q;
        wbrw_d  = rw_q;
      end else if (cnt_q == TO_LAST) begin
        // Abort: write back a harmless no-op so the pipeline keeps its entry count.
        state_d = ST_IDLE;
        cnt_d   = '0;
        req_d   = 1'b0;
        wbv_d   = 1'b1;
        wbd_d   = '0;
        wbrd_d  = rd_q;
        wbrw_d  = 1'b0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sz_q    <= '0;
      uns_q   <= 1'b0;
      st_q    <= 1'b0;
      off_q   <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wbv_q   <= 1'b0;
      wbd_q   <= '0;
      wbrd_q  <= '0;
      wbrw_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sz_q    <= sz_d;
      uns_q   <= uns_d;
      st_q    <= st_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wbv_q   <= wbv_d;
      wbd_q   <= wbd_d;
      wbrd_q  <= wbrd_d;
      wbrw_q  <= wbrw_d;
      err_q   <= err_d;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  // Gated by rst_n so every output reads 0 while reset is asserted.
  assign bus.stall        = rst_n && ((state_q == ST_BUSY) || take_mem);
  assign bus.dmem_req     = req_q;
  assign bus.dmem_we      = we_q;
  assign bus.dmem_addr    = addr_q;
  assign bus.dmem_wdata   = wdata_q;
  assign bus.dmem_wstrb   = wstrb_q;
  assign bus.wb_valid     = wbv_q;
  assign bus.wb_data      = wbd_q;
  assign bus.wb_rd        = wbrd_q;
  assign bus.wb_reg_write = wbrw_q;
  assign bus.mem_err      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads/stores, timeout, reset while BUSY, misaligned access.
module tb_mem_stage;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   sc;
  int   n;
  logic seen;

  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_wstrb;
  logic        obs_req, obs_we;

  mem_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  mem_stage #(.DATA_W(32), .REG_AW(5), .ACK_TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] sd,
                       input logic [3:0] op, input logic [4:0] rd, input logic rw);
    bus.in_valid      = v;
    bus.in_data       = d;
    bus.in_store_data = sd;
    bus.in_mem_op     = op;
    bus.in_rd         = rd;
    bus.in_reg_write  = rw;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 4'b0000, 5'd0, 1'b0);
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
  endtask

  // Issues one memory op, holds it through BUSY, acks in BUSY cycle ack_cycle; returns stall-high cycles.
  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input int ack_cycle, input logic [31:0] rdata,
                         output int stall_cycles);
    stall_cycles = 0;
    drive(1'b1, addr, sd, op, rd, 1'b1);
    #1;
    if (bus.stall) stall_cycles++;
    tick();
    obs_req   = bus.dmem_req;
    obs_we    = bus.dmem_we;
    obs_addr  = bus.dmem_addr;
    obs_wdata = bus.dmem_wdata;
    obs_wstrb = bus.dmem_wstrb;
    for (int c = 1; c <= ack_cycle; c++) begin
      if (c == ack_cycle) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
      end
      if (bus.stall) stall_cycles++;
      tick();
    end
    idle();
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    idle();
    repeat (3) tick();
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'h0);
    check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_mem_err", 32'(bus.mem_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU pass-through
    drive(1'b1, 32'h0000_1234, 32'h0, 4'b0000, 5'd5, 1'b1);
    #1;
    check("add_stall", 32'(bus.stall), 32'd0);
    tick();
    idle();
    check("add_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("add_wb_data", bus.wb_data, 32'h0000_1234);
    check("add_wb_rd", 32'(bus.wb_rd), 32'd5);
    check("add_wb_rw", 32'(bus.wb_reg_write), 32'd1);
    tick();
    check("idle_wb_valid", 32'(bus.wb_valid), 32'd0);

    drive(1'b1, 32'h0000_DEAD, 32'h0, 4'b0000, 5'd0, 1'b1);
    tick();
    idle();
    check("x0_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("x0_wb_rw", 32'(bus.wb_reg_write), 32'd0);

    // LB at 0x103, ack in second BUSY cycle
    run_mem(4'b0001, 32'h0000_0103, 32'h0, 5'd7, 2, 32'h80FF_0000, sc);
    check("lb_stall_cycles", 32'(sc), 32'd3);
    check("lb_req", 32'(obs_req), 32'd1);
    check("lb_addr", obs_addr, 32'h0000_0100);
    check("lb_we", 32'(obs_we), 32'd0);
    check("lb_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("lb_wb_data", bus.wb_data, 32'hFFFF_FF80);
    check("lb_wb_rd", 32'(bus.wb_rd), 32'd7);
    check("lb_wb_rw", 32'(bus.wb_reg_write), 32'd1);
    check("lb_req_after", 32'(bus.dmem_req), 32'd0);
    check("lb_stall_after", 32'(bus.stall), 32'd0);

    run_mem(4'b1001, 32'h0000_0103, 32'h0, 5'd7, 2, 32'h80FF_0000, sc);
    check("lbu_wb_data", bus.wb_data, 32'h0000_0080);

    // SH at 0x202
    run_mem(4'b0110, 32'h0000_0202, 32'hABCD_1234, 5'd8, 1, 32'h0, sc);
    check("sh_stall_cycles", 32'(sc), 32'd2);
    check("sh_wstrb", 32'(obs_wstrb), 32'h0000_000C);
    check("sh_wdata", obs_wdata, 32'h1234_1234);
    check("sh_we", 32'(obs_we), 32'd1);
    check("sh_addr", obs_addr, 32'h0000_0200);
    check("sh_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("sh_wb_rw", 32'(bus.wb_reg_write), 32'd0);
    check("sh_wb_data", bus.wb_data, 32'h0);

    run_mem(4'b0101, 32'h0000_0201, 32'h0000_00AB, 5'd8, 1, 32'h0, sc);
    check("sb_wstrb", 32'(obs_wstrb), 32'h0000_0002);
    check("sb_wdata", obs_wdata, 32'hABAB_ABAB);

    run_mem(4'b0111, 32'h0000_0204, 32'h1122_3344, 5'd8, 1, 32'h0, sc);
    check("sw_wstrb", 32'(obs_wstrb), 32'h0000_000F);
    check("sw_wdata", obs_wdata, 32'h1122_3344);

    run_mem(4'b0010, 32'h0000_0102, 32'h0, 5'd9, 1, 32'h8001_7FFF, sc);
    check("lh_wb_data", bus.wb_data, 32'hFFFF_8001);
    run_mem(4'b1010, 32'h0000_0100, 32'h0, 5'd9, 3, 32'h8001_FFFF, sc);
    check("lhu_stall_cycles", 32'(sc), 32'd4);
    check("lhu_wb_data", bus.wb_data, 32'h0000_FFFF);
    run_mem(4'b0011, 32'h0000_0108, 32'h0, 5'd9, 1, 32'hDEAD_BEEF, sc);
    check("lw_wb_data", bus.wb_data, 32'hDEAD_BEEF);

    // Stray ack while IDLE
    bus.dmem_ack = 1'b1;
    tick();
    idle();
    check("stray_ack_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("stray_ack_req", 32'(bus.dmem_req), 32'd0);

    // Timeout
    drive(1'b1, 32'h0000_0400, 32'h0, 4'b0011, 5'd9, 1'b1);
    tick();
    check("to_req", 32'(bus.dmem_req), 32'd1);
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.mem_err) begin
        seen = 1'b1;
        break;
      end
      n++;
      tick();
    end
    check("to_seen", 32'(seen), 32'd1);
    check("to_busy_cycles", 32'(n), 32'd255);
    check("to_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("to_wb_rw", 32'(bus.wb_reg_write), 32'd0);
    check("to_req_dropped", 32'(bus.dmem_req), 32'd0);
    idle();
    #1;
    check("to_stall_released", 32'(bus.stall), 32'd0);
    tick();
    check("to_err_pulse", 32'(bus.mem_err), 32'd0);

    // Reset while BUSY
    drive(1'b1, 32'h0000_0500, 32'h0, 4'b0011, 5'd3, 1'b1);
    tick();
    check("rb_req", 32'(bus.dmem_req), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rb_req_clr", 32'(bus.dmem_req), 32'd0);
    check("rb_stall_clr", 32'(bus.stall), 32'd0);
    check("rb_addr_clr", bus.dmem_addr, 32'h0);
    check("rb_wb_valid", 32'(bus.wb_valid), 32'd0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    check("rb_no_stale_wb", 32'(bus.wb_valid), 32'd0);
    drive(1'b1, 32'h0000_0055, 32'h0, 4'b0000, 5'd4, 1'b1);
    tick();
    idle();
    check("rb_add_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("rb_add_wb_data", bus.wb_data, 32'h0000_0055);
    check("rb_add_wb_rw", 32'(bus.wb_reg_write), 32'd1);

    // Misaligned word access
`ifdef MEM_MISALIGN_TRAP_EN
    drive(1'b1, 32'h0000_0301, 32'h0, 4'b0011, 5'd6, 1'b1);
    #1;
    check("mis_stall", 32'(bus.stall), 32'd0);
    tick();
    idle();
    check("mis_trap", 32'(bus.misalign_trap), 32'd1);
    check("mis_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("mis_wb_data", bus.wb_data, 32'h0000_0301);
    check("mis_wb_rw", 32'(bus.wb_reg_write), 32'd0);
    check("mis_req", 32'(bus.dmem_req), 32'd0);
    tick();
    check("mis_trap_pulse", 32'(bus.misalign_trap), 32'd0);
`else
    run_mem(4'b0011, 32'h0000_0301, 32'h0, 5'd6, 1, 32'hCAFE_F00D, sc);
    check("mis_addr", obs_addr, 32'h0000_0300);
    check("mis_req", 32'(obs_req), 32'd1);
    check("mis_wb_data", bus.wb_data, 32'hCAFE_F00D);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
